riscv_mem_arbiter: RTL and testbench

//  Shares one memory port between the IF-stage instruction fetcher (I) and the MEM-stage load/store unit (D).

---
 rtl/riscv_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between the instruction fetcher (I) and the load/store unit (D).
// One outstanding transaction, combinational grant and response forwarding, stale-fetch drop.
module riscv_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               lock_q, lock_d;
  logic               own_q, own_d;      // locked owner: 1 = D, 0 = I
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               drop_q, drop_d;

  logic               resp;
  logic               window;
  logic               pick_dside;
  logic               grant;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lock_q   <= 1'b0;
      own_q    <= 1'b0;
      starve_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      own_q    <= own_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
    end
  end

  // Arbitration, response routing and next-state
  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    own_d      = own_q;
    starve_d   = starve_q;
    drop_d     = drop_q;
    m_req      = 1'b0;
    m_we       = 1'b0;
    m_be       = '0;
    m_addr     = '0;
    m_wdata    = '0;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    i_rdata    = '0;
    d_rvalid   = 1'b0;
    d_rdata    = '0;
    pick_dside = 1'b0;

    resp   = m_rvalid & (state_q != IDLE);
    window = ~rst & ((state_q == IDLE) | resp);

    if (lock_q) begin
      pick_dside = own_q;
    end else if ((starve_q == CNT_W'(STARVE_MAX)) && i_req) begin
      pick_dside = 1'b0;
    end else begin
      pick_dside = d_req;
    end

    m_req = window & (pick_dside ? d_req : i_req);
    if (m_req) begin
      if (pick_dside) begin
        m_we    = d_we;
        m_be    = d_be;
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end else begin
        m_be    = {BE_W{1'b1}};
        m_addr  = i_addr;
      end
    end

    grant = m_req & m_gnt;
    i_gnt = grant & ~pick_dside;
    d_gnt = grant & pick_dside;

    if (m_req && !m_gnt) begin
      lock_d = 1'b1;
      own_d  = pick_dside;
    end else if (grant) begin
      lock_d = 1'b0;
    end

    if (!i_req || i_gnt) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != CNT_W'(STARVE_MAX))) begin
      starve_d = starve_q + CNT_W'(1);
    end

    if (resp && (state_q == WAIT_D)) begin
      d_rvalid = 1'b1;
      d_rdata  = m_rdata;
    end
    if (resp && (state_q == WAIT_I)) begin
      i_rvalid = ~(drop_q | i_flush);
      i_rdata  = m_rdata;
    end

    // Drop only tags the fetch currently outstanding, never a new one granted alongside its response
    if (state_q == WAIT_I) begin
      if (m_rvalid) begin
        drop_d = 1'b0;
      end else if (i_flush) begin
        drop_d = 1'b1;
      end
    end

    if (grant) begin
      state_d = pick_dside ? WAIT_D : WAIT_I;
    end else if (resp) begin
      state_d = IDLE;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomized and directed bench for riscv_mem_arbiter against a transaction-level reference model.
module tb_riscv_mem_arbiter;

  localparam int unsigned STARVE = 4;

  logic        clk, rst;
  logic        i_req, i_flush, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_gnt, m_rvalid;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: who owns the bus, who is waiting on a stalled request, fairness streak
  int outst  = 0;   // 0 none, 1 fetch, 2 data
  int held   = 0;   // requester stalled by m_gnt=0
  int streak = 0;   // D grants in a row while a fetch waits
  bit stale  = 0;   // outstanding fetch was redirected away
  int mem_wait = 0;
  int lat_fix  = 0;

  int obs_ig, obs_dg, obs_irv;
  logic        last_i_gnt, last_d_gnt, last_i_rvalid, last_d_rvalid, last_m_we;
  logic [31:0] last_i_rdata, last_m_addr;
  logic [3:0]  last_m_be;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare DUT against model mid-low-phase, advance model, let requesters/memory react
  task automatic cycle();
    bit resp, win, pick, want, eg_i, eg_d;
    logic [31:0] ea, ew, eir, edr;
    logic [3:0]  eb;
    #1;
    resp = m_rvalid && (outst != 0);
    win  = (outst == 0) || resp;
    if (held != 0) pick = (held == 2);
    else if (streak == STARVE && i_req) pick = 1'b0;
    else pick = d_req;
    want = win && (pick ? d_req : i_req);
    eg_i = want && m_gnt && !pick;
    eg_d = want && m_gnt && pick;
    ea   = want ? (pick ? d_addr : i_addr) : 32'h0;
    eb   = want ? (pick ? d_be : 4'hF) : 4'h0;
    ew   = (want && pick) ? d_wdata : 32'h0;
    eir  = (resp && outst == 1) ? m_rdata : 32'h0;
    edr  = (resp && outst == 2) ? m_rdata : 32'h0;

    check_eq("m_req", 64'(m_req), 64'(want));
    check_eq("m_addr", 64'(m_addr), 64'(ea));
    check_eq("m_we", 64'(m_we), 64'(want && pick && d_we));
    check_eq("m_be", 64'(m_be), 64'(eb));
    check_eq("m_wdata", 64'(m_wdata), 64'(ew));
    check_eq("i_gnt", 64'(i_gnt), 64'(eg_i));
    check_eq("d_gnt", 64'(d_gnt), 64'(eg_d));
    check_eq("i_rvalid", 64'(i_rvalid), 64'(resp && outst == 1 && !(stale || i_flush)));
    check_eq("d_rvalid", 64'(d_rvalid), 64'(resp && outst == 2));
    check_eq("i_rdata", 64'(i_rdata), 64'(eir));
    check_eq("d_rdata", 64'(d_rdata), 64'(edr));

    last_i_gnt = i_gnt; last_d_gnt = d_gnt; last_i_rvalid = i_rvalid; last_d_rvalid = d_rvalid;
    last_i_rdata = i_rdata; last_m_addr = m_addr; last_m_we = m_we; last_m_be = m_be;
    obs_ig += int'(i_gnt); obs_dg += int'(d_gnt); obs_irv += int'(i_rvalid);

    if (want && !m_gnt) held = pick ? 2 : 1;
    else if (want) held = 0;
    if (!i_req || eg_i) streak = 0;
    else if (eg_d && streak < STARVE) streak++;
    if (outst == 1 && resp) stale = 0;
    else if (outst == 1 && i_flush) stale = 1;
    if (want && m_gnt) begin
      outst    = pick ? 2 : 1;
      mem_wait = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
    end else if (resp) begin
      outst = 0;
    end

    @(posedge clk);
    @(negedge clk);
    if (eg_i) i_req = 1'b0;
    if (eg_d) d_req = 1'b0;
    i_flush  = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = $urandom;
    if (mem_wait > 0) begin
      mem_wait--;
      if (mem_wait == 0) m_rvalid = 1'b1;
    end
  endtask

  task automatic drain();
    i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b1;
    for (int k = 0; k < 8; k++) cycle();
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    m_gnt = 1'b1; m_rvalid = 1'b0; m_rdata = '0;
    obs_ig = 0; obs_dg = 0; obs_irv = 0;
    @(negedge clk);
    #1;
    check_eq("rst_m_req", 64'(m_req), 64'(0));
    check_eq("rst_gnts", 64'({i_gnt, d_gnt}), 64'(0));
    check_eq("rst_rvalid", 64'({i_rvalid, d_rvalid}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Single fetch, immediate grant, one-cycle latency
    lat_fix = 1;
    i_req = 1'b1; i_addr = 32'h100;
    cycle();
    check_eq("t1_i_gnt", 64'(last_i_gnt), 64'(1));
    m_rdata = 32'hDEADBEEF;
    cycle();
    check_eq("t1_i_rvalid", 64'(last_i_rvalid), 64'(1));
    check_eq("t1_i_rdata", 64'(last_i_rdata), 64'(32'hDEADBEEF));
    check_eq("t1_d_rvalid", 64'(last_d_rvalid), 64'(0));
    drain();

    // Simultaneous store and fetch: D first, I in the D response cycle
    i_req = 1'b1; i_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_be = 4'b0011; d_wdata = 32'h1234_5678;
    cycle();
    check_eq("t2_d_gnt", 64'(last_d_gnt), 64'(1));
    check_eq("t2_m_we", 64'(last_m_we), 64'(1));
    check_eq("t2_m_be", 64'(last_m_be), 64'(4'b0011));
    cycle();
    check_eq("t2_d_rvalid", 64'(last_d_rvalid), 64'(1));
    check_eq("t2_i_gnt", 64'(last_i_gnt), 64'(1));
    drain();

    // Starvation: continuous D traffic with a waiting fetch
    obs_ig = 0; obs_dg = 0;
    i_req = 1'b1; i_addr = 32'h108;
    for (int k = 0; k < 40; k++) begin
      if (!d_req) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = 32'h300 + 32'(k * 4);
        d_be = 4'hF; d_wdata = $urandom;
      end
      cycle();
      if (last_i_gnt) break;
    end
    check_eq("t3_i_gnt_seen", 64'(obs_ig), 64'(1));
    check_eq("t3_d_before_i", 64'(obs_dg), 64'(STARVE));
    drain();

    // Lock: memory stalls a D request while a fetch shows up
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_be = 4'hF; d_wdata = 32'h0;
    obs_ig = 0;
    for (int k = 0; k < 3; k++) begin
      m_gnt = 1'b0;
      if (k == 1) begin i_req = 1'b1; i_addr = 32'h10C; end
      cycle();
      check_eq("t4_lock_addr", 64'(last_m_addr), 64'(32'h400));
    end
    m_gnt = 1'b1;
    cycle();
    check_eq("t4_d_gnt", 64'(last_d_gnt), 64'(1));
    check_eq("t4_no_i_gnt", 64'(obs_ig), 64'(0));
    drain();

    // Redirect drops the outstanding fetch; the fetch issued with its response survives
    obs_irv = 0;
    lat_fix = 3;
    i_req = 1'b1; i_addr = 32'h500;
    cycle();
    cycle();
    i_flush = 1'b1;
    cycle();
    lat_fix = 1;
    i_req = 1'b1; i_addr = 32'h600;
    cycle();
    check_eq("t5_dropped", 64'(last_i_rvalid), 64'(0));
    check_eq("t5_new_gnt", 64'(last_i_gnt), 64'(1));
    m_rdata = 32'h13;
    cycle();
    check_eq("t5_rvalid", 64'(last_i_rvalid), 64'(1));
    check_eq("t5_rdata", 64'(last_i_rdata), 64'(32'h13));
    check_eq("t5_count", 64'(obs_irv), 64'(1));
    drain();

    // Reset while a load is outstanding
    lat_fix = 3;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; d_be = 4'hF;
    cycle();
    i_req = 1'b1; i_addr = 32'h800; m_rvalid = 1'b1; rst = 1'b1;
    #1;
    check_eq("t6_m_req", 64'(m_req), 64'(0));
    check_eq("t6_m_addr", 64'(m_addr), 64'(0));
    check_eq("t6_rvalid", 64'({i_rvalid, d_rvalid}), 64'(0));
    check_eq("t6_gnt", 64'({i_gnt, d_gnt}), 64'(0));
    @(negedge clk);
    rst = 1'b0; m_rvalid = 1'b0; d_req = 1'b0;
    outst = 0; held = 0; streak = 0; stale = 0; mem_wait = 0;
    lat_fix = 1;
    cycle();
    check_eq("t6_i_gnt", 64'(last_i_gnt), 64'(1));
    drain();

    // Randomized traffic
    lat_fix = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!i_req && ($urandom % 2 == 0)) begin
        i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && ($urandom % 10 < 7)) begin
        d_req = 1'b1; d_we = 1'($urandom); d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      m_gnt   = ($urandom % 4 != 0);
      i_flush = ($urandom % 8 == 0);
      if (outst == 0 && mem_wait == 0 && ($urandom % 16 == 0)) m_rvalid = 1'b1;
      cycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
